// File: rtl/bcd_seq_conv_pkg.sv
// Shared constants and types for the iterative binary-to-BCD converter.
// The default input width matches the RPM measurement path.
package bcd_seq_conv_pkg;

  localparam int RPM_WIDTH   = 16;
  localparam int BCD_DIGIT_W = 4;

  typedef logic [BCD_DIGIT_W-1:0] digit_t;

  // A digit that is 5 or more gets 3 added, so that the next left shift
  // carries correctly into the next decimal digit.
  localparam digit_t ADD3_THRESH = digit_t'(5);
  localparam digit_t ADD3_INC    = digit_t'(3);

  typedef enum logic {
    IDLE,
    SHIFT
  } state_e;

endpackage

// File: rtl/bcd_seq_conv_add3.sv
// Double-dabble correction cell for one BCD digit.
// Adds 3 when the digit is 5 or more, otherwise passes it through unchanged.
module bcd_add3
  import bcd_seq_conv_pkg::*;
(
  input  logic [BCD_DIGIT_W-1:0] digit_i,
  output logic [BCD_DIGIT_W-1:0] digit_o
);

  assign digit_o = (digit_i >= ADD3_THRESH) ? digit_i + ADD3_INC : digit_i;

endmodule

// File: rtl/bcd_seq_conv.sv
// Iterative binary-to-BCD converter (shift-and-add-3), one input bit per cycle.
// Presents saturated BCD digits, an overflow flag and a leading-zero blanking mask.
module bcd_seq_conv
  import bcd_seq_conv_pkg::*;
#(
  parameter int BIN_WIDTH = RPM_WIDTH,
  parameter int DIGITS    = 4
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     start,
  input  logic [BIN_WIDTH-1:0]     value,
  output logic                     busy,
  output logic                     valid,
  output logic [4*DIGITS-1:0]      bcd,
  output logic [DIGITS-1:0]        blank,
  output logic                     overflow
);

  localparam int ACC_W = BCD_DIGIT_W * DIGITS;
  localparam int CNT_W = $clog2(BIN_WIDTH + 1);

  localparam logic [ACC_W-1:0]  ALL_NINES = {DIGITS{4'h9}};
  localparam logic [DIGITS-1:0] BLANK_RST = ~DIGITS'(1);

  state_e                 state_q, state_d;
  logic [BIN_WIDTH-1:0]   bin_sh_q, bin_sh_d;
  logic [ACC_W-1:0]       bcd_acc_q, bcd_acc_d;
  logic                   ovf_sticky_q, ovf_sticky_d;
  logic [CNT_W-1:0]       cnt_q, cnt_d;
  logic                   valid_q, valid_d;
  logic [ACC_W-1:0]       bcd_q, bcd_d;
  logic [DIGITS-1:0]      blank_q, blank_d;
  logic                   overflow_q, overflow_d;

  logic [ACC_W-1:0]       corr;
  logic [ACC_W-1:0]       acc_shift;
  logic                   ovf_shift;
  logic [ACC_W-1:0]       bcd_fin;
  logic [DIGITS-1:0]      blank_fin;
  logic                   zero_run;
  logic                   last_iter;

  for (genvar g = 0; g < DIGITS; g++) begin : g_add3
    bcd_add3 u_add3 (
      .digit_i (bcd_acc_q[BCD_DIGIT_W*g +: BCD_DIGIT_W]),
      .digit_o (corr[BCD_DIGIT_W*g +: BCD_DIGIT_W])
    );
  end

  // The bit leaving the top digit after correction means the value no
  // longer fits in DIGITS decimal digits.
  assign acc_shift = {corr[ACC_W-2:0], bin_sh_q[BIN_WIDTH-1]};
  assign ovf_shift = ovf_sticky_q | corr[ACC_W-1];
  assign bcd_fin   = ovf_shift ? ALL_NINES : acc_shift;
  assign last_iter = (cnt_q == CNT_W'(1));

  always_comb begin
    zero_run  = 1'b1;
    blank_fin = '0;
    for (int k = DIGITS - 1; k > 0; k--) begin
      zero_run     = zero_run & (bcd_fin[BCD_DIGIT_W*k +: BCD_DIGIT_W] == '0);
      blank_fin[k] = zero_run;
    end
  end

  // NOTE: sequential state uses non-blocking assignments so every flop
  // samples the pre-edge values regardless of process ordering.
  always_ff @(posedge clk) begin
    if (reset) state_q <= IDLE;
    else       state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:  if (start)     state_d = SHIFT;
      SHIFT: if (last_iter) state_d = IDLE;
    endcase
  end

  // NOTE: every combinational output is given a hold/default value first,
  // so no path through the branches can infer a latch.
  always_comb begin
    bin_sh_d     = bin_sh_q;
    bcd_acc_d    = bcd_acc_q;
    ovf_sticky_d = ovf_sticky_q;
    cnt_d        = cnt_q;
    valid_d      = 1'b0;
    bcd_d        = bcd_q;
    blank_d      = blank_q;
    overflow_d   = overflow_q;
    unique case (state_q)
      IDLE: begin
        if (start) begin
          bin_sh_d     = value;
          bcd_acc_d    = '0;
          ovf_sticky_d = 1'b0;
          cnt_d        = CNT_W'(BIN_WIDTH);
        end
      end
      SHIFT: begin
        bin_sh_d     = bin_sh_q << 1;
        bcd_acc_d    = acc_shift;
        ovf_sticky_d = ovf_shift;
        cnt_d        = cnt_q - CNT_W'(1);
        if (last_iter) begin
          valid_d    = 1'b1;
          bcd_d      = bcd_fin;
          blank_d    = blank_fin;
          overflow_d = ovf_shift;
        end
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      bin_sh_q     <= '0;
      bcd_acc_q    <= '0;
      ovf_sticky_q <= 1'b0;
      cnt_q        <= '0;
      valid_q      <= 1'b0;
      bcd_q        <= '0;
      blank_q      <= BLANK_RST;
      overflow_q   <= 1'b0;
    end else begin
      bin_sh_q     <= bin_sh_d;
      bcd_acc_q    <= bcd_acc_d;
      ovf_sticky_q <= ovf_sticky_d;
      cnt_q        <= cnt_d;
      valid_q      <= valid_d;
      bcd_q        <= bcd_d;
      blank_q      <= blank_d;
      overflow_q   <= overflow_d;
    end
  end

  assign busy     = (state_q == SHIFT);
  assign valid    = valid_q;
  assign bcd      = bcd_q;
  assign blank    = blank_q;
  assign overflow = overflow_q;

endmodule

// File: tb/tb_bcd_seq_conv.sv
// Scoreboard bench for bcd_seq_conv: a 4-digit and a 5-digit instance share
// stimulus; expected results come from decimal arithmetic on the input value.
module tb_bcd_seq_conv;

  logic        clk = 1'b0;
  logic        reset;
  logic        start;
  logic [15:0] value;

  logic        busy4, valid4, ovf4;
  logic [15:0] bcd4;
  logic [3:0]  blank4;
  logic        busy5, valid5, ovf5;
  logic [19:0] bcd5;
  logic [4:0]  blank5;

  int checks   = 0;
  int failures = 0;

  typedef struct {
    logic [19:0] bcd;
    logic [4:0]  blank;
    logic        ovf;
    int unsigned v;
  } exp_t;

  exp_t q4[$];
  exp_t q5[$];
  exp_t e4, e5;

  always #5 clk = ~clk;

  bcd_seq_conv #(.BIN_WIDTH(16), .DIGITS(4)) dut4 (
    .clk      (clk),
    .reset    (reset),
    .start    (start),
    .value    (value),
    .busy     (busy4),
    .valid    (valid4),
    .bcd      (bcd4),
    .blank    (blank4),
    .overflow (ovf4)
  );

  bcd_seq_conv #(.BIN_WIDTH(16), .DIGITS(5)) dut5 (
    .clk      (clk),
    .reset    (reset),
    .start    (start),
    .value    (value),
    .busy     (busy5),
    .valid    (valid5),
    .bcd      (bcd5),
    .blank    (blank5),
    .overflow (ovf5)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference: decimal digits by repeated division, saturation against 10^d.
  function automatic exp_t model(input int unsigned v, input int d);
    exp_t        e;
    int unsigned lim, r, p;
    e.bcd   = '0;
    e.blank = '0;
    e.ovf   = 1'b0;
    e.v     = v;
    lim     = 1;
    for (int k = 0; k < d; k++) lim = lim * 10;
    if (v >= lim) begin
      e.ovf = 1'b1;
      for (int k = 0; k < d; k++) e.bcd[4*k +: 4] = 4'd9;
    end else begin
      r = v;
      for (int k = 0; k < d; k++) begin
        e.bcd[4*k +: 4] = 4'(r % 10);
        r = r / 10;
      end
      p = 10;
      for (int k = 1; k < d; k++) begin
        e.blank[k] = (v < p);
        p = p * 10;
      end
    end
    return e;
  endfunction

  // Monitor: pops and compares whenever a result is presented.
  always @(negedge clk) begin
    if (valid4) begin
      if (q4.size() == 0) begin
        check("d4_unexpected_valid", 32'(valid4), 32'd0);
      end else begin
        e4 = q4.pop_front();
        check($sformatf("d4_bcd(%0d)", e4.v),   32'(bcd4),   32'(e4.bcd[15:0]));
        check($sformatf("d4_blank(%0d)", e4.v), 32'(blank4), 32'(e4.blank[3:0]));
        check($sformatf("d4_ovf(%0d)", e4.v),   32'(ovf4),   32'(e4.ovf));
      end
    end
    if (valid5) begin
      if (q5.size() == 0) begin
        check("d5_unexpected_valid", 32'(valid5), 32'd0);
      end else begin
        e5 = q5.pop_front();
        check($sformatf("d5_bcd(%0d)", e5.v),   32'(bcd5),   32'(e5.bcd));
        check($sformatf("d5_blank(%0d)", e5.v), 32'(blank5), 32'(e5.blank));
        check($sformatf("d5_ovf(%0d)", e5.v),   32'(ovf5),   32'(e5.ovf));
      end
    end
  end

  // Drives start for one cycle; value is scrambled right after acceptance.
  task automatic issue(input logic [15:0] v, input bit track);
    start = 1'b1;
    value = v;
    if (track) begin
      q4.push_back(model(32'(v), 4));
      q5.push_back(model(32'(v), 5));
    end
    @(negedge clk);
    start = 1'b0;
    value = 16'($urandom);
  endtask

  // Counts remaining busy cycles (bounded) and expects valid right after.
  task automatic wait_done(input int exp_cycles, input string tag);
    int n;
    n = 0;
    while (busy4 && n < 100) begin
      n++;
      @(negedge clk);
    end
    check({tag, "_busy_cycles"}, 32'(n), 32'(exp_cycles));
    check({tag, "_valid_after_busy"}, 32'(valid4), 32'd1);
  endtask

  task automatic check_reset_state(input string tag);
    check({tag, "_busy"},   32'(busy4),  32'd0);
    check({tag, "_valid"},  32'(valid4), 32'd0);
    check({tag, "_bcd"},    32'(bcd4),   32'd0);
    check({tag, "_blank"},  32'(blank4), 32'b1110);
    check({tag, "_ovf"},    32'(ovf4),   32'd0);
    check({tag, "_busy5"},  32'(busy5),  32'd0);
    check({tag, "_bcd5"},   32'(bcd5),   32'd0);
    check({tag, "_blank5"}, 32'(blank5), 32'b11110);
  endtask

  logic [15:0] directed [8] = '{16'd1234, 16'd0, 16'd7, 16'd305,
                                 16'd9999, 16'd10000, 16'd65535, 16'd99};

  initial begin
    reset = 1'b1;
    start = 1'b0;
    value = '0;
    repeat (3) @(negedge clk);
    check_reset_state("reset");
    reset = 1'b0;
    @(negedge clk);

    foreach (directed[i]) begin
      issue(directed[i], 1'b1);
      wait_done(16, $sformatf("dir%0d", i));
    end

    // start while busy is ignored; then a start in the valid cycle is taken
    repeat (2) @(negedge clk);
    issue(16'd1234, 1'b1);
    repeat (4) @(negedge clk);
    start = 1'b1;
    value = 16'd42;
    @(negedge clk);
    start = 1'b0;
    wait_done(11, "ignored_start");
    issue(16'd42, 1'b1);
    wait_done(16, "back_to_back");

    // reset mid-conversion, with a competing start in the reset cycle
    @(negedge clk);
    issue(16'd1234, 1'b0);
    repeat (7) @(negedge clk);
    reset = 1'b1;
    start = 1'b1;
    value = 16'd55;
    @(negedge clk);
    reset = 1'b0;
    start = 1'b0;
    check_reset_state("abort");
    repeat (20) @(negedge clk);
    check("abort_still_idle", 32'(busy4), 32'd0);

    // randomized values with random idle gaps (gap 0 = back-to-back)
    for (int i = 0; i < 40; i++) begin
      logic [15:0] v;
      case ($urandom_range(0, 3))
        0:       v = 16'($urandom_range(0, 99));
        1:       v = 16'($urandom_range(9990, 10010));
        2:       v = 16'($urandom_range(99990, 65535) & 16'hFFFF);
        default: v = 16'($urandom);
      endcase
      repeat ($urandom_range(0, 3)) @(negedge clk);
      issue(v, 1'b1);
      wait_done(16, $sformatf("rnd%0d", i));
    end

    repeat (3) @(negedge clk);
    check("d4_queue_drained", 32'(q4.size()), 32'd0);
    check("d5_queue_drained", 32'(q5.size()), 32'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish within time limit");
    $fatal(1);
  end

endmodule
